// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM state encoding,
// IR field positions and small opcode-class helpers.
package cpu_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_ANDI = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_NEG  = 5'b01110;
  localparam logic [4:0] OP_NOT  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field bit positions
  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;
  localparam int IMM_MSB = 18;

  typedef enum logic [3:0] {
    RST_ST, FETCH0, FETCH1, FETCH2, EX3, EX4, EX5, EX6, PAUSED, HALTED
  } state_t;

  // Three-operand register ops, including MUL/DIV
  function automatic logic is_rtype(logic [4:0] op);
    return (op <= OP_ROL) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_imm(logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_unary(logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Immediate forms reuse the ALU's register-form operation
  function automatic logic [4:0] alu_map(logic [4:0] op);
    case (op)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return op;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// reg_select: 4-bit register number to 16-bit one-hot strobe, gated by en.
//   en     - strobe enable
//   sel    - register number
//   onehot - one-hot output, all zero when en is low
module reg_select (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign onehot[i] = en && (sel == 4'(i));
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM fetching instructions and driving datapath
// strobes for register/immediate ALU ops, MUL/DIV, NEG/NOT, NOP and HALT.
//   clk, clear     - clock, async active-low reset
//   ir             - instruction register contents
//   mem_ready      - memory read data valid during FETCH1
//   stop           - pause at the next instruction boundary
//   PC/MAR/MDR/IR/Y/Z/HI/LO strobes, reg_in/reg_out one-hot, alu_op, imm_out
//   run            - low in reset, paused or halted
//   illegal_op     - one-cycle pulse on an undefined opcode
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        IncPC,
  output logic        PC_enable,
  output logic        MAR_enable,
  output logic        mdr_read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IR_enable,
  output logic        Yin,
  output logic        ZHigh_enable,
  output logic        ZLow_enable,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIin,
  output logic        LOin,
  output logic        Cout,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic [4:0]  alu_op,
  output logic [31:0] imm_out,
  output logic        run,
  output logic        illegal_op
);

  state_t      state, nxt;
  logic [1:0]  hold_cnt;
  logic        f1_wait;   // already spent a cycle waiting in FETCH1
  logic        rin_en, rout_en;
  logic [3:0]  rout_sel;
  state_t      boundary;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  assign op = ir[OPC_LSB+:5];
  assign ra = ir[RA_LSB+:4];
  assign rb = ir[RB_LSB+:4];
  assign rc = ir[RC_LSB+:4];

  // Every path back to FETCH0 honours a pending stop request
  assign boundary = stop ? PAUSED : FETCH0;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= RST_ST;
      hold_cnt <= '0;
      f1_wait  <= 1'b0;
    end else begin
      state    <= nxt;
      hold_cnt <= (state == RST_ST) ? hold_cnt + 2'd1 : 2'd0;
      f1_wait  <= (state == FETCH1) && !mem_ready;
    end
  end

  always_comb begin
    nxt          = state;
    PCout        = 1'b0;
    IncPC        = 1'b0;
    PC_enable    = 1'b0;
    MAR_enable   = 1'b0;
    mdr_read     = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IR_enable    = 1'b0;
    Yin          = 1'b0;
    ZHigh_enable = 1'b0;
    ZLow_enable  = 1'b0;
    ZHighout     = 1'b0;
    ZLowout      = 1'b0;
    HIin         = 1'b0;
    LOin         = 1'b0;
    Cout         = 1'b0;
    alu_op       = '0;
    illegal_op   = 1'b0;
    rin_en       = 1'b0;
    rout_en      = 1'b0;
    rout_sel     = rb;
    case (state)
      RST_ST: if (hold_cnt == 2'(RESET_PC_HOLD - 1)) nxt = boundary;
      FETCH0: begin
        PCout       = 1'b1;
        MAR_enable  = 1'b1;
        IncPC       = 1'b1;
        ZLow_enable = 1'b1;
        nxt         = FETCH1;
      end
      FETCH1: begin
        ZLowout   = 1'b1;
        PC_enable = !f1_wait;  // PC loads once, not on every wait cycle
        mdr_read  = 1'b1;
        MDRin     = 1'b1;
        if (mem_ready) nxt = FETCH2;
      end
      FETCH2: begin
        MDRout    = 1'b1;
        IR_enable = 1'b1;
        if (op == OP_NOP)       nxt = boundary;
        else if (op == OP_HALT) nxt = HALTED;
        else                    nxt = EX3;
      end
      EX3: begin
        if (is_unary(op)) begin
          rout_en     = 1'b1;
          alu_op      = alu_map(op);
          ZLow_enable = 1'b1;
          nxt         = EX5;
        end else if (is_rtype(op) || is_imm(op)) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
          nxt     = EX4;
        end else begin
          illegal_op = 1'b1;
          nxt        = boundary;
        end
      end
      EX4: begin
        if (is_imm(op)) Cout = 1'b1;
        else begin
          rout_en  = 1'b1;
          rout_sel = rc;
        end
        alu_op       = alu_map(op);
        ZLow_enable  = 1'b1;
        ZHigh_enable = is_muldiv(op);
        nxt          = EX5;
      end
      EX5: begin
        ZLowout = 1'b1;
        if (is_muldiv(op)) begin
          LOin = 1'b1;
          nxt  = EX6;
        end else begin
          rin_en = 1'b1;
          nxt    = boundary;
        end
      end
      EX6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
        nxt      = boundary;
      end
      PAUSED:  if (!stop) nxt = FETCH0;
      HALTED:  nxt = HALTED;
      default: nxt = RST_ST;
    endcase
  end

  reg_select u_rin  (.en(rin_en),  .sel(ra),       .onehot(reg_in));
  reg_select u_rout (.en(rout_en), .sel(rout_sel), .onehot(reg_out));

  assign run     = !(state inside {RST_ST, PAUSED, HALTED});
  assign imm_out = (state == RST_ST) ? '0 : {{(31-IMM_MSB){ir[IMM_MSB]}}, ir[IMM_MSB:0]};

endmodule

// File: tb/tb_control_sequencer.sv
// Trace-level bench: each instruction is expanded into its expected per-cycle
// strobe pattern from the instruction-class rules, then played cycle by cycle.
module tb_control_sequencer;

  localparam int HOLD = 2;

  logic        clk = 1'b0, clear = 1'b0, mem_ready = 1'b0, stop = 1'b0;
  logic [31:0] ir = '0;
  logic PCout, IncPC, PC_enable, MAR_enable, mdr_read, MDRin, MDRout, IR_enable;
  logic Yin, ZHigh_enable, ZLow_enable, ZHighout, ZLowout, HIin, LOin, Cout;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  alu_op;
  logic [31:0] imm_out;
  logic        run, illegal_op;

  control_sequencer #(.RESET_PC_HOLD(HOLD)) dut (
    .clk(clk), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .IncPC(IncPC), .PC_enable(PC_enable), .MAR_enable(MAR_enable),
    .mdr_read(mdr_read), .MDRin(MDRin), .MDRout(MDRout), .IR_enable(IR_enable),
    .Yin(Yin), .ZHigh_enable(ZHigh_enable), .ZLow_enable(ZLow_enable),
    .ZHighout(ZHighout), .ZLowout(ZLowout), .HIin(HIin), .LOin(LOin), .Cout(Cout),
    .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op), .imm_out(imm_out),
    .run(run), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcout, incpc, pc_en, mar_en, mdr_read, mdrin, mdrout, ir_en;
    logic yin, zh_en, zl_en, zhout, zlout, hiin, loin, cout;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  alu_op;
    logic        run, ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] ir;
    bit          mr, st, ck_imm;
    logic [31:0] imm;
  } cyc_t;

  vec_t obs;
  assign obs = {PCout, IncPC, PC_enable, MAR_enable, mdr_read, MDRin, MDRout, IR_enable,
                Yin, ZHigh_enable, ZLow_enable, ZHighout, ZLowout, HIin, LOin, Cout,
                reg_in, reg_out, alu_op, run, illegal_op};

  cyc_t q[$];
  int   errs = 0, checks = 0, ncyc = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic vec_t idle(bit r);
    vec_t v;
    v = '0;
    v.run = r;
    return v;
  endfunction

  task automatic push(vec_t v, logic [31:0] i, bit mr, bit st);
    cyc_t c;
    c.v = v; c.ir = i; c.mr = mr; c.st = st; c.ck_imm = 1'b0; c.imm = '0;
    q.push_back(c);
  endtask

  // Expected trace for one instruction; optional stop at its end plus pause cycles
  task automatic gen_instr(logic [31:0] i, int waits, bit stop_end, int pause_len);
    int   op, ra, rb, rc;
    bit   muldiv, unary, imm, rtype;
    logic [4:0] aop;
    vec_t v;
    op = int'(i[31:27]); ra = int'(i[26:23]); rb = int'(i[22:19]); rc = int'(i[18:15]);
    muldiv = (op == 12) || (op == 13);
    unary  = (op == 14) || (op == 15);
    imm    = (op >= 9) && (op <= 11);
    rtype  = (op <= 8) || muldiv;
    aop    = (op == 9) ? 5'd0 : (op == 10) ? 5'd2 : (op == 11) ? 5'd3 : 5'(op);

    v = idle(1); v.pcout = 1; v.incpc = 1; v.mar_en = 1; v.zl_en = 1;
    push(v, i, 0, 0);
    for (int w = 0; w <= waits; w++) begin
      v = idle(1); v.zlout = 1; v.mdr_read = 1; v.mdrin = 1; v.pc_en = (w == 0);
      push(v, i, w == waits, 0);
    end
    v = idle(1); v.mdrout = 1; v.ir_en = 1;
    push(v, i, 0, 0);
    if (op == 27) return;
    if (op != 26) begin
      if (unary) begin
        v = idle(1); v.reg_out = 16'h1 << rb; v.alu_op = aop; v.zl_en = 1;
        push(v, i, 0, 0);
        v = idle(1); v.zlout = 1; v.reg_in = 16'h1 << ra;
        push(v, i, 0, 0);
      end else if (rtype || imm) begin
        v = idle(1); v.reg_out = 16'h1 << rb; v.yin = 1;
        push(v, i, 0, 0);
        v = idle(1); v.alu_op = aop; v.zl_en = 1; v.zh_en = muldiv;
        if (imm) v.cout = 1; else v.reg_out = 16'h1 << rc;
        push(v, i, 0, 0);
        v = idle(1); v.zlout = 1;
        if (muldiv) v.loin = 1; else v.reg_in = 16'h1 << ra;
        push(v, i, 0, 0);
        if (muldiv) begin
          v = idle(1); v.zhout = 1; v.hiin = 1;
          push(v, i, 0, 0);
        end
      end else begin
        v = idle(1); v.ill = 1;
        push(v, i, 0, 0);
      end
    end
    if (stop_end) begin
      q[q.size()-1].st = 1;
      q[q.size()-2].st = 1;
      for (int p = 0; p < pause_len; p++) push(idle(0), i, 0, p != pause_len - 1);
    end
  endtask

  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      ir = c.ir; mem_ready = c.mr; stop = c.st;
      @(negedge clk);
      chk($sformatf("cyc%0d", ncyc), 64'(obs), 64'(c.v));
      if (c.ck_imm) chk($sformatf("imm%0d", ncyc), 64'(imm_out), 64'(c.imm));
      ncyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b0;
    #1;
    chk("clr_async", 64'(obs), 64'(idle(0)));
    chk("clr_imm", 64'(imm_out), 64'd0);
    @(posedge clk); #1;
    clear = 1'b1;
    for (int k = 0; k < HOLD; k++) push(idle(0), ir, 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ops[21];
    logic [31:0] ri;
    ops = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,26,21,16,31,28};

    // Reset state with a nonzero immediate on ir
    ir = 32'h492FFFFD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", 64'(obs), 64'(idle(0)));
    chk("rst_imm", 64'(imm_out), 64'd0);
    clear = 1'b1;
    for (int k = 0; k < HOLD; k++) push(idle(0), ir, 0, 0);

    // Directed instructions
    gen_instr(32'h01A38000, 0, 0, 0);                      // ADD r3,r4,r7
    gen_instr(32'h492FFFFD, 0, 0, 0);                      // ADDI r2,r5,-3
    q[q.size()-2].ck_imm = 1; q[q.size()-2].imm = 32'hFFFFFFFD;
    gen_instr({5'b01100, 4'd1, 4'd2, 4'd3, 15'd0}, 2, 0, 0); // MUL, 2 wait cycles
    gen_instr(32'h01A38000, 0, 1, 3);                      // ADD with stop in EX4
    gen_instr({5'b10101, 4'd6, 4'd1, 4'd2, 15'd0}, 0, 0, 0); // undefined opcode
    gen_instr({5'b01110, 4'd9, 4'd10, 4'd0, 15'd0}, 1, 0, 0); // NEG
    gen_instr({5'b11010, 27'd0}, 0, 1, 1);                 // NOP then pause
    gen_instr({5'b01010, 4'd15, 4'd0, 19'h1234}, 0, 0, 0); // ANDI
    play();

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      ri = $urandom;
      ri[31:27] = 5'(ops[$urandom_range(0, 20)]);
      gen_instr(ri, int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                int'($urandom_range(1, 3)));
    end
    play();

    // clear asserted during a FETCH1 wait
    gen_instr({5'b01101, 4'd4, 4'd5, 4'd6, 15'd0}, 5, 0, 0);
    while (q.size() > 3) void'(q.pop_back());
    play();
    mem_ready = 1'b0;
    #1;
    pulse_clear();
    gen_instr({5'b01111, 4'd11, 4'd12, 4'd0, 15'd0}, 0, 0, 0); // NOT
    play();

    // HALT is sticky until clear
    gen_instr({5'b11011, 27'd0}, 0, 0, 0);
    for (int k = 0; k < 4; k++) push(idle(0), {5'b11011, 27'd0}, 0, k == 1);
    play();
    pulse_clear();
    gen_instr(32'h01A38000, 1, 0, 0);
    play();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
